microcode_sequencer: RTL



---
 rtl/microcode_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/microcode_sequencer.sv
// ---------------------------------------------------------------------------
// microcode_sequencer
//
// Steps through microcode held in an external synchronous-read ROM
// (one-cycle read latency, address = {opcode, step}) and turns each ROM word
// into a one-cycle control strobe for the datapath. Each micro-step takes a
// FETCH cycle (address presented, ROM samples it on the closing edge) and an
// EXEC cycle (ROM data valid, driven out as the control word).
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   run_i        - advance enable; low holds the sequencer in FETCH
//   opcode_i     - opcode field from the instruction register
//   rom_addr_o   - ROM read address {opcode_i, step}
//   rom_data_i   - ROM read data, valid one clock after the address
//   ctrl_o       - control word; zero outside EXEC
//   ctrl_stb_o   - high exactly in EXEC cycles
//   step_o       - current step index
//   instr_done_o - one-cycle pulse in the EXEC that ends an instruction
//   halted_o     - machine halted (until reset)
// ---------------------------------------------------------------------------
module microcode_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 4,
  parameter int CTRL_W   = 16,
  parameter int MAX_STEP = 4,
  parameter int HLT_BIT  = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run_i,
  input  logic [OPCODE_W-1:0]        opcode_i,
  output logic [OPCODE_W+STEP_W-1:0] rom_addr_o,
  input  logic [CTRL_W-1:0]          rom_data_i,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic                       ctrl_stb_o,
  output logic [STEP_W-1:0]          step_o,
  output logic                       instr_done_o,
  output logic                       halted_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] MAX_STEP_C = STEP_W'(MAX_STEP);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                stb_q, stb_d;
  logic                halted_q, halted_d;
  logic                done;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run_i) state_d = S_EXEC;
      end
      S_EXEC: begin
        // Halt has priority over the zero-word and last-step terminations.
        if (rom_data_i[HLT_BIT]) begin
          state_d = S_HALT;
          done    = 1'b1;
        end else if (rom_data_i == '0) begin
          state_d = S_FETCH;
          step_d  = '0;
          done    = 1'b1;
        end else if (step_q == MAX_STEP_C) begin
          state_d = S_FETCH;
          step_d  = '0;
          done    = 1'b1;
        end else begin
          state_d = S_FETCH;
          step_d  = step_q + 1'b1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
        step_d  = '0;
      end
    endcase
    // Strobe and halt flags are registered copies of the next-state decode.
    stb_d    = (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      step_q   <= '0;
      stb_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      stb_q    <= stb_d;
      halted_q <= halted_d;
    end
  end

  // ROM data is only meaningful in EXEC, so the control word is gated by the
  // registered strobe; reset clears the strobe and thus the word immediately.
  assign rom_addr_o   = {opcode_i, step_q};
  assign ctrl_o       = stb_q ? rom_data_i : '0;
  assign ctrl_stb_o   = stb_q;
  assign step_o       = step_q;
  assign instr_done_o = done;
  assign halted_o     = halted_q;

endmodule
